// File: rtl/quant_router_if.sv
// Handshake bundle for quant_router: upstream accumulator beats in,
// quantized beats out, plus the saturation counter.
interface quant_router_if #(
    parameter int ACCUMULATE = 32,
    parameter int OUT_WIDTH  = 8
) ();
    logic                             in_valid;
    logic                             in_ready;
    logic [3:0][ACCUMULATE-1:0]       in_data;
    logic [4:0]                       shift;
    logic [OUT_WIDTH-1:0]             zero_point;
    logic                             out_valid;
    logic                             out_ready;
    logic [3:0][OUT_WIDTH-1:0]        out_data;
    logic [15:0]                      sat_count;

    modport master (
        output in_valid, in_data, shift, zero_point, out_ready,
        input  in_ready, out_valid, out_data, sat_count
    );

    modport slave (
        input  in_valid, in_data, shift, zero_point, out_ready,
        output in_ready, out_valid, out_data, sat_count
    );
endinterface

// File: rtl/quant_router.sv
// Four-lane requantizer: rounding right shift, zero-point add with
// saturation, then a small output FIFO with credit-style in_ready.
module quant_router #(
    parameter int ACCUMULATE = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           reset,
    quant_router_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = ACCUMULATE + 1;
    localparam int ZW = ACCUMULATE + 2;
    localparam logic signed [ZW-1:0] MAXV =
        ZW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ZW-1:0] MINV = ~MAXV;

    typedef logic [3:0][OUT_WIDTH-1:0] beat_t;

    logic                  w_in_fire;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_out_valid;
    logic signed [SW-1:0]  w_bias;
    logic signed [SW-1:0]  w_ext [4];
    logic signed [SW-1:0]  w_sum [4];
    logic signed [SW-1:0]  w_shr [4];
    logic signed [ZW-1:0]  w_zp;
    logic signed [ZW-1:0]  w_zsum [4];
    beat_t                 w_q;
    logic [3:0]            w_sat;
    logic [2:0]            w_nsat;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW:0]           w_tot_nxt;
    logic [16:0]           w_sat_acc;

    logic                  r_in_ready;
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic [3:0][SW-1:0]    r_s1_data;
    logic [OUT_WIDTH-1:0]  r_s1_zp;
    beat_t                 r_s2_data;
    logic [2:0]            r_s2_nsat;
    beat_t                 r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [15:0]           r_sat_cnt;

    assign w_in_fire   = bus.in_valid & r_in_ready;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_wr        = r_s2_valid;

    // Round-half-up bias; ACCUMULATE+1 bits keeps acc + bias from overflowing.
    assign w_bias = (bus.shift == 5'd0) ? '0
                  : (SW'(1) << (bus.shift - 5'd1));
    assign w_zp   = {{(ZW-OUT_WIDTH){r_s1_zp[OUT_WIDTH-1]}}, r_s1_zp};

    always_comb begin
        w_nsat = '0;
        for (int i = 0; i < 4; i++) begin
            w_ext[i]  = {bus.in_data[i][ACCUMULATE-1], bus.in_data[i]};
            w_sum[i]  = w_ext[i] + w_bias;
            w_shr[i]  = w_sum[i] >>> bus.shift;
            w_zsum[i] = {r_s1_data[i][SW-1], r_s1_data[i]} + w_zp;
            w_sat[i]  = 1'b0;
            if (w_zsum[i] > MAXV) begin
                w_q[i]   = MAXV[OUT_WIDTH-1:0];
                w_sat[i] = 1'b1;
            end else if (w_zsum[i] < MINV) begin
                w_q[i]   = MINV[OUT_WIDTH-1:0];
                w_sat[i] = 1'b1;
            end else begin
                w_q[i]   = w_zsum[i][OUT_WIDTH-1:0];
            end
            w_nsat = w_nsat + 3'(w_sat[i]);
        end
    end

    // Credits cover FIFO entries plus both pipeline stages, so nothing drops.
    assign w_cnt_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    assign w_tot_nxt = {1'b0, w_cnt_nxt}
                     + (CW+1)'(r_s1_valid)
                     + (CW+1)'(w_in_fire);
    assign w_sat_acc = {1'b0, r_sat_cnt} + 17'(r_s2_nsat);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_sat_cnt  <= '0;
        end else begin
            r_in_ready <= (w_tot_nxt < (CW+1)'(DEPTH));
            r_s1_valid <= w_in_fire;
            r_s2_valid <= r_s1_valid;
            r_count    <= w_cnt_nxt;
            if (w_wr) begin
                r_wptr    <= r_wptr + AW'(1);
                r_sat_cnt <= w_sat_acc[16] ? 16'hFFFF : w_sat_acc[15:0];
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int i = 0; i < 4; i++) begin
                r_s1_data[i] <= w_shr[i];
            end
            r_s1_zp <= bus.zero_point;
        end
        if (r_s1_valid) begin
            r_s2_data <= w_q;
            r_s2_nsat <= w_nsat;
        end
        if (w_wr) begin
            r_mem[r_wptr] <= r_s2_data;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rptr] : '0;
    assign bus.sat_count = r_sat_cnt;
endmodule

// File: tb/tb_quant_router.sv
// Bench for quant_router: vector table plus a scoreboard queue
// checked by an output monitor, with hand sequences for backpressure/reset.
module tb_quant_router;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    quant_router_if #(.ACCUMULATE(32), .OUT_WIDTH(8)) bus ();

    quant_router #(.ACCUMULATE(32), .OUT_WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          lane [4];
        int          sh;
        int          zp;
        logic [31:0] exp;
        int          nsat;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          sat_exp  = 0;
    logic [31:0] q [$];
    int          pop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t tv(input int a, input int b, input int c,
                                input int d, input int sh, input int zp,
                                input logic [31:0] exp, input int ns);
        vec_t v;
        v.lane = '{a, b, c, d};
        v.sh   = sh;
        v.zp   = zp;
        v.exp  = exp;
        v.nsat = ns;
        return v;
    endfunction

    // Reference: round-half-up shift, add zp, clamp to int8.
    function automatic vec_t mk(input int a, input int b, input int c,
                                input int d, input int sh, input int zp);
        vec_t   v;
        longint x;
        v.lane = '{a, b, c, d};
        v.sh   = sh;
        v.zp   = zp;
        v.nsat = 0;
        v.exp  = '0;
        for (int i = 0; i < 4; i++) begin
            x = longint'(v.lane[i]);
            if (sh != 0) x = (x + (longint'(1) <<< (sh - 1))) >>> sh;
            x = x + longint'(zp);
            if (x > 127) begin
                x = 127;
                v.nsat++;
            end else if (x < -128) begin
                x = -128;
                v.nsat++;
            end
            v.exp[i*8 +: 8] = 8'(x);
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < 4; i++) bus.in_data[i] = 32'(v.lane[i]);
        bus.shift      = 5'(v.sh);
        bus.zero_point = 8'(v.zp);
    endtask

    task automatic push(input vec_t v);
        q.push_back(v.exp);
        sat_exp += v.nsat;
    endtask

    task automatic send(input vec_t v, output int waited);
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready %b, required 1", bus.in_ready);
        end else begin
            push(v);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) bus.in_data[i] = $urandom();
        bus.shift      = 5'($urandom());
        bus.zero_point = 8'($urandom());
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((q.size() != 0 || bus.out_valid) && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", q.size(), 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (reset === 1'b1 && bus.out_valid === 1'b1 &&
            bus.out_ready === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got %0h, required no beat",
                         bus.out_data);
            end else begin
                chk("out_data", bus.out_data, q.pop_front());
            end
        end
    end

    initial begin
        vec_t tbl [5];
        vec_t bp  [6];
        vec_t v;
        int   w;
        int   tot;
        int   idx;

        tbl[0] = tv(32, 40, -24, 7, 4, 0, pk(2, 3, -1, 0), 0);
        tbl[1] = tv(200, -300, 117, 118, 0, 10,
                    pk(127, -128, 127, 127), 3);
        tbl[2] = tv(int'(32'h8000_0000), int'(32'h7FFF_FFFF),
                    int'(32'h4000_0000), -1, 31, -5,
                    pk(-6, -4, -4, -5), 0);
        tbl[3] = tv(-3, 3, -1, 1000, 1, -128,
                    pk(-128, -126, -128, 127), 2);
        tbl[4] = tv(-32768, 255, 128, 127, 8, 127,
                    pk(-1, 127, 127, 127), 2);

        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.shift      = '0;
        bus.zero_point = '0;
        for (int i = 0; i < 4; i++) bus.in_data[i] = '0;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_sat", bus.sat_count, 0);
            chk("rst_out_data", bus.out_data, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_out_valid", bus.out_valid, 0);

        // Latency: accepted at edge k, visible after edge k+2
        send(tbl[0], w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("lat_k0", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_k1", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_k2", bus.out_valid, 1);
        wait_drain();

        foreach (tbl[n]) begin
            send(tbl[n], w);
            idle();
            wait_drain();
            chk("sat_count", bus.sat_count, 32'(sat_exp));
        end

        // Backpressure: only four credits, then ordered drain
        for (int i = 0; i < 6; i++)
            bp[i] = mk(i * 16, -i * 9, i * 100 - 250, 1 << i, 2, i - 3);
        bus.out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if ((k == 8 || k == 14) && q.size() != 0)
                chk("bp_hold_head", bus.out_data, q[0]);
            if (k == 14) begin
                chk("bp_accepted", idx, 4);
                chk("bp_in_ready", bus.in_ready, 0);
            end
            if (k == 15) begin
                chk("full_pop_ready", bus.in_ready, 0);
                bus.out_ready = 1'b1;
            end
            if (k == 16) chk("ready_after_pop", bus.in_ready, 1);
            if (idx < 6) begin
                drive(bp[idx]);
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    push(bp[idx]);
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        wait_drain();
        chk("bp_all_sent", idx, 6);
        chk("bp_sat", bus.sat_count, 32'(sat_exp));

        // Streaming: one beat per cycle, no bubbles
        pop_cyc.delete();
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            v = mk(i * 29 - 280, i * 29 - 277, i * 29 - 274, i * 29 - 271,
                   1, 0);
            send(v, w);
            tot += w;
        end
        idle();
        wait_drain();
        chk("tp_stall", tot, 0);
        chk("tp_count", pop_cyc.size(), 20);
        if (pop_cyc.size() == 20)
            chk("tp_span", pop_cyc[19] - pop_cyc[0], 19);
        chk("tp_sat", bus.sat_count, 32'(sat_exp));

        // Reset mid-operation discards buffered beats
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = mk(1000 + i, 2000 + i, -1000 - i, 5, 4, 1);
            send(v, w);
        end
        idle();
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", bus.out_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_sat", bus.sat_count, 0);
        q.delete();
        sat_exp = 0;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        pop_cyc.delete();
        send(mk(-7, 9, 300, -300, 1, 3), w);
        send(mk(64, 65, 66, 67, 3, -2), w);
        idle();
        repeat (4) @(negedge clk);
        wait_drain();
        chk("post_rst_count", pop_cyc.size(), 2);
        chk("post_rst_sat", bus.sat_count, 32'(sat_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/quant_router.md
QUANT_ROUTER -- requirements
Module: quant_router

Interface
REQ-001 Parameter ACCUMULATE, default 32, SHALL set the signed accumulator lane width.
REQ-002 Parameter OUT_WIDTH, default 8, SHALL set the signed quantized lane width.
REQ-003 Parameter DEPTH, default 4, SHALL set the output FIFO depth in beats; power of two, at least 2.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL flag a valid upstream beat.
REQ-007 in_ready  output  1  SHALL flag that a beat is accepted this cycle.
REQ-008 in_data  input  ACCUMULATE x [3:0]  SHALL carry four signed lanes from the array result.
REQ-009 shift  input  5  SHALL carry the right-shift amount (0-31), sampled with the beat.
REQ-010 zero_point  input  OUT_WIDTH  SHALL carry a signed offset, sampled with the beat.
REQ-011 out_valid  output  1  SHALL flag a valid quantized beat at the FIFO head.
REQ-012 out_ready  input  1  SHALL flag downstream acceptance.
REQ-013 out_data  output  OUT_WIDTH x [3:0]  SHALL carry the four signed quantized lanes.
REQ-014 sat_count  output  16  SHALL carry the running count of saturated lanes.

Function
REQ-015 A beat SHALL transfer on a rising edge where in_valid and in_ready are both high; out likewise with out_valid and out_ready.
REQ-016 Stage 1 SHALL register, per lane: shift=0 -> acc; else (acc + 2^(shift-1)) >>> shift, computed at ACCUMULATE+1 bits with no intermediate overflow.
REQ-017 Stage 2 SHALL add sign-extended zero_point, saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and write the beat into the FIFO.
REQ-018 Latency: a beat accepted at edge k SHALL be written at edge k+2; when the FIFO is empty, out_valid SHALL be high after edge k+2.
REQ-019 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-020 in_ready SHALL be registered and high iff (FIFO occupancy + valid stage-1/2 entries) < DEPTH, so no accepted beat is ever dropped.
REQ-021 A pop and a stage-2 write on the same edge SHALL both take effect; occupancy is unchanged, including when full.
REQ-022 A pop on a full FIFO SHALL NOT raise in_ready in the same cycle; it rises after the next edge.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; beats SHALL leave in acceptance order.
REQ-024 out_data SHALL be the FIFO head, held stable while out_valid is high and out_ready is low.
REQ-025 sat_count SHALL add the number of lanes saturated in each stage-2 write (0-4) and clamp at 16'hFFFF.
REQ-026 in_data, shift and zero_point SHALL be ignored when no input transfer occurs.

Reset
REQ-027 While reset is low at an edge: out_valid=0, out_data=0, sat_count=0, in_ready=0, both stage valids=0, pointers=0.
REQ-028 in_ready SHALL go high on the first edge with reset high.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered beats; none SHALL appear after release.

Verification
REQ-030 Hold reset low 2 cycles, then release -> out_valid=0, sat_count=0 throughout; in_ready=1 after the first edge with reset high.
REQ-031 Send one beat: shift=4, zp=0, lanes {32, 40, -24, 7} -> out_data {2, 3, -1, 0}; out_valid rises after edge k+2.
REQ-032 Send one beat: shift=0, zp=10, lanes {200, -300, 117, 118} -> out_data {127, -128, 127, 127}; sat_count=3.
REQ-033 Hold out_ready=0 and offer 6 beats -> exactly 4 accepted, in_ready low; then set out_ready=1 -> beats 1-4 drain in order, then beats 5-6 accepted and delivered.
REQ-034 Keep in_valid=1 and out_ready=1 for 20 beats with shift=1 and incrementing data -> one output per cycle after a 2-cycle fill, values correct, no gaps.
REQ-035 Buffer 3 beats, pulse reset low 1 cycle -> out_valid=0 after that edge; after release, only post-reset beats emerge.
